iram_loader: RTL and testbench

Byte-stream programmer for the instruction RAM. It receives a framed program image (length, opcode bytes, checksum) over a valid/ready byte interface, such as a UART receiver. It writes each opcode byte sequentially into the IRAM write port starting at address 0. The processor is held in reset/stall via `proc_hold` for the whole load and is released only after a frame with a correct checksum.

---
 rtl/iram_loader_if.sv | 33 +++
 rtl/iram_loader.sv | 152 +++++++++++++++
 tb/tb_iram_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iram_loader_if.sv
// Byte-stream input and IRAM write port of the instruction-RAM loader.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready handshake on the byte stream; the IRAM port has none.
interface iram_loader_if #(
    parameter int AW = 8
) ();
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          iram_we;
    logic [AW-1:0] iram_addr;
    logic [7:0]    iram_wdata;

    // Loader side: consumes bytes, drives the IRAM write port.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output iram_we,
        output iram_addr,
        output iram_wdata
    );

    // Environment side: byte source and IRAM.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  iram_we,
        input  iram_addr,
        input  iram_wdata
    );
endinterface

// File: rtl/iram_loader.sv
// Loads a framed program image (LEN, opcodes, CSUM) into IRAM, holding the processor until a good checksum.
// Latency: an opcode accepted at edge k is written during cycle k+1; done/err appear the cycle after CSUM.
// Backpressure: in_ready is registered from state; low in IDLE, DONE and ERR so no byte is consumed there.
module iram_loader #(
    parameter int DEPTH = 121,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    iram_loader_if.slave  bus,
    output logic          proc_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Largest legal LEN byte; the frame length field is a single byte.
    localparam logic [7:0] MAX_LEN = 8'(DEPTH);

    state_t        state_q,      state_d;
    logic [AW-1:0] len_q,        len_d;
    logic [7:0]    sum_q,        sum_d;
    logic [AW-1:0] wptr_q,       wptr_d;
    logic          in_ready_q,   in_ready_d;
    logic          iram_we_q,    iram_we_d;
    logic [AW-1:0] iram_addr_q,  iram_addr_d;
    logic [7:0]    iram_wdata_q, iram_wdata_d;
    logic          proc_hold_q,  proc_hold_d;
    logic          done_q,       done_d;
    logic          err_q,        err_d;

    logic          accept;
    logic [7:0]    csum_total;

    assign accept     = bus.in_valid & in_ready_q;
    assign csum_total = sum_q + bus.in_data;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sum_d        = sum_q;
        wptr_d       = wptr_q;
        iram_we_d    = 1'b0;
        iram_addr_d  = iram_addr_q;
        iram_wdata_d = iram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if ((bus.in_data == 8'd0) || (bus.in_data > MAX_LEN)) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = AW'(bus.in_data);
                        sum_d   = bus.in_data;
                        wptr_d  = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    iram_we_d    = 1'b1;
                    iram_addr_d  = wptr_q;
                    iram_wdata_d = bus.in_data;
                    sum_d        = csum_total;
                    wptr_d       = wptr_q + AW'(1);
                    // Last opcode of the frame: the next byte is the checksum.
                    if (wptr_q == (len_q - AW'(1))) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (csum_total == 8'd0) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the state being entered,
        // so they line up with the state they describe.
        in_ready_d  = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        proc_hold_d = (state_d == ST_LEN) || (state_d == ST_DATA) ||
                      (state_d == ST_CSUM) || (state_d == ST_ERR);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
    end

    // State and output registers with synchronous reset; reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            sum_q        <= '0;
            wptr_q       <= '0;
            in_ready_q   <= 1'b0;
            iram_we_q    <= 1'b0;
            iram_addr_q  <= '0;
            iram_wdata_q <= '0;
            proc_hold_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            wptr_q       <= wptr_d;
            in_ready_q   <= in_ready_d;
            iram_we_q    <= iram_we_d;
            iram_addr_q  <= iram_addr_d;
            iram_wdata_q <= iram_wdata_d;
            proc_hold_q  <= proc_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.iram_we    = iram_we_q;
    assign bus.iram_addr  = iram_addr_q;
    assign bus.iram_wdata = iram_wdata_q;
    assign proc_hold      = proc_hold_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: good/bad frames, illegal lengths, max length with gaps, reset and stray start.
// Latency: checks done/err one cycle after CSUM and writes one cycle after each accepted opcode.
// Backpressure: source holds in_valid until in_ready; gaps inserted between bytes.
module tb_iram_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic proc_hold;
    logic done;
    logic err;

    iram_loader_if #(.AW(8)) bus ();

    iram_loader #(.DEPTH(121), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .proc_hold (proc_hold),
        .done      (done),
        .err       (err)
    );

    int checks   = 0;
    int failures = 0;

    // Monitor state: writes seen, done pulses, writes without a preceding accepted byte.
    int         cyc      = 0;
    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         bad_wr   = 0;
    logic       acc_last = 1'b0;
    logic [7:0] wr_addr [0:255];
    logic [7:0] wr_data [0:255];
    int         wr_cyc  [0:255];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.iram_we) begin
            if (!acc_last) bad_wr++;
            if (wr_cnt < 256) begin
                wr_addr[wr_cnt] = bus.iram_addr;
                wr_data[wr_cnt] = bus.iram_wdata;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end
        if (done) done_cnt++;
        acc_last = bus.in_valid & bus.in_ready & !rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt   = 0;
        done_cnt = 0;
        bad_wr   = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: byte=%0h not accepted within 50 cycles", b);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_good_frame();
        send(8'h03, 0);
        send(8'h07, 0);
        send(8'h08, 0);
        send(8'h13, 0);
        send(8'hDB, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  bus.in_ready,   0);
        check("rst_we",        bus.iram_we,    0);
        check("rst_addr",      bus.iram_addr,  0);
        check("rst_wdata",     bus.iram_wdata, 0);
        check("rst_hold",      proc_hold,      0);
        check("rst_done",      done,           0);
        check("rst_err",       err,            0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", bus.in_ready,   0);

        // Good load
        clear_mon();
        pulse_start();
        check("good_hold_rise", proc_hold,    1);
        check("good_rdy_len",   bus.in_ready, 1);
        send_good_frame();
        check("good_done",      done,         1);
        check("good_hold_drop", proc_hold,    0);
        check("good_err",       err,          0);
        check("good_rdy_done",  bus.in_ready, 0);
        check("good_wr_cnt",    wr_cnt,       3);
        check("good_a0",        wr_addr[0],   8'h00);
        check("good_d0",        wr_data[0],   8'h07);
        check("good_a1",        wr_addr[1],   8'h01);
        check("good_d1",        wr_data[1],   8'h08);
        check("good_a2",        wr_addr[2],   8'h02);
        check("good_d2",        wr_data[2],   8'h13);
        check("good_b2b_1",     wr_cyc[1] - wr_cyc[0], 1);
        check("good_b2b_2",     wr_cyc[2] - wr_cyc[1], 1);
        tick();
        check("good_done_1cyc", done,         0);
        check("good_done_cnt",  done_cnt,     1);
        check("good_hold_idle", proc_hold,    0);
        check("good_hold_addr", bus.iram_addr,  8'h02);
        check("good_hold_data", bus.iram_wdata, 8'h13);

        // Bad checksum, then recovery
        clear_mon();
        pulse_start();
        send(8'h03, 0);
        send(8'h07, 0);
        send(8'h08, 0);
        send(8'h13, 0);
        send(8'hDC, 0);
        check("bad_err",        err,          1);
        check("bad_done",       done,         0);
        check("bad_hold",       proc_hold,    1);
        check("bad_rdy",        bus.in_ready, 0);
        repeat (3) tick();
        check("bad_err_sticky", err,          1);
        check("bad_hold_stay",  proc_hold,    1);
        check("bad_wr_cnt",     wr_cnt,       3);
        check("bad_done_cnt",   done_cnt,     0);
        pulse_start();
        check("bad_err_clear",  err,          0);
        check("bad_restart_hold", proc_hold,  1);
        send_good_frame();
        check("rec_done",       done,         1);
        check("rec_hold",       proc_hold,    0);
        tick();
        check("rec_done_cnt",   done_cnt,     1);

        // Illegal lengths
        clear_mon();
        pulse_start();
        send(8'h00, 0);
        check("len0_err",       err,          1);
        check("len0_rdy",       bus.in_ready, 0);
        check("len0_hold",      proc_hold,    1);
        pulse_start();
        send(8'h7A, 0);
        check("len122_err",     err,          1);
        repeat (3) tick();
        check("badlen_no_wr",   wr_cnt,       0);

        // Max length with random gaps, starting from ERR
        clear_mon();
        pulse_start();
        send(8'h79, $urandom_range(0, 2));
        for (int i = 0; i < 121; i++) begin
            send(8'(i), $urandom_range(0, 2));
        end
        send(8'h2B, $urandom_range(0, 2));
        check("max_done",       done,         1);
        check("max_err",        err,          0);
        check("max_hold",       proc_hold,    0);
        tick();
        check("max_wr_cnt",     wr_cnt,       121);
        check("max_stray_wr",   bad_wr,       0);
        mism = 0;
        for (int i = 0; i < 121; i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== 8'(i)) mism++;
        end
        check("max_order",      mism,         0);

        // Reset mid-DATA after 2 of 3 opcodes
        clear_mon();
        pulse_start();
        send(8'h03, 0);
        send(8'h07, 0);
        send(8'h08, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_rdy",    bus.in_ready,   0);
        check("mid_rst_we",     bus.iram_we,    0);
        check("mid_rst_addr",   bus.iram_addr,  0);
        check("mid_rst_wdata",  bus.iram_wdata, 0);
        check("mid_rst_hold",   proc_hold,      0);
        check("mid_rst_done",   done,           0);
        check("mid_rst_err",    err,            0);
        rst = 1'b0;
        repeat (3) tick();
        check("mid_rst_wr_cnt", wr_cnt,       2);
        clear_mon();
        pulse_start();
        send_good_frame();
        check("post_rst_done",  done,         1);
        tick();
        check("post_rst_wr",    wr_cnt,       3);
        check("post_rst_d2",    wr_data[2],   8'h13);

        // start during DATA and during DONE is ignored
        clear_mon();
        pulse_start();
        send(8'h03, 0);
        send(8'h07, 0);
        pulse_start();
        check("st_data_rdy",    bus.in_ready, 1);
        check("st_data_hold",   proc_hold,    1);
        send(8'h08, 0);
        send(8'h13, 0);
        send(8'hDB, 0);
        check("st_done_pulse",  done,         1);
        pulse_start();
        check("st_done_ign_rdy",  bus.in_ready, 0);
        check("st_done_ign_hold", proc_hold,    0);
        repeat (3) tick();
        check("st_idle_hold",   proc_hold,    0);
        check("st_done_cnt",    done_cnt,     1);
        check("st_wr_cnt",      wr_cnt,       3);
        check("st_a2",          wr_addr[2],   8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
